// File: rtl/dbg_trace_avalon_poller.sv
// Avalon-MM host that polls the debug-trace agent's 64-bit history word, turns new
// bytes into (sample, seq) entries in an output FIFO, and forwards partition-enable writes.
module dbg_trace_avalon_poller #(
  parameter int POLL_INTERVAL = 64,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [63:0] avm_readdata,
  output logic        avm_write,
  output logic [63:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic        en_valid,
  input  logic [4:0]  en_data,
  output logic        en_ready,
  output logic [4:0]  en_shadow,
  output logic        smp_valid,
  output logic [7:0]  smp_data,
  output logic [7:0]  smp_seq,
  input  logic        smp_ready,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic [15:0] lost_count
);

  // state  | meaning
  // IDLE   | waiting: accept enable update or count down to next poll
  // WR     | Avalon write of partition enables to address 1
  // RD     | Avalon read of trace word at address 0
  // PUSH   | pushing decoded samples into the FIFO, oldest first
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_PUSH} state_t;

  localparam int TW = $clog2(POLL_INTERVAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    last_seq;
  logic [4:0]    en_latched;
  logic [63:0]   trace;
  logic [2:0]    idx;

  logic [7:0]    rd_seq;
  logic [7:0]    rd_delta;
  logic [16:0]   lost_sum;
  logic [15:0]   lost_next;

  assign rd_seq    = avm_readdata[63:56];
  assign rd_delta  = rd_seq - last_seq;
  assign lost_sum  = {1'b0, lost_count} + {9'b0, rd_delta - 8'd7};
  assign lost_next = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];

  logic       push_valid;
  logic [7:0] push_data;
  logic [7:0] push_seq;

  assign push_valid = (state == S_PUSH);
  assign push_data  = trace[{idx, 3'b000} +: 8];
  assign push_seq   = trace[63:56] - {5'b0, idx};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      timer         <= TW'(POLL_INTERVAL);
      last_seq      <= '0;
      en_latched    <= '0;
      trace         <= '0;
      idx           <= '0;
      avm_address   <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      en_ready      <= 1'b0;
      en_shadow     <= '0;
      lost_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_valid && en_ready) begin
            en_latched    <= en_data;
            avm_write     <= 1'b1;
            avm_address   <= 1'b1;
            avm_writedata <= {59'b0, en_data};
            en_ready      <= 1'b0;
            state         <= S_WR;
          end else if (timer <= TW'(1)) begin
            timer       <= TW'(POLL_INTERVAL);
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            en_ready    <= 1'b0;
            state       <= S_RD;
          end else begin
            timer    <= timer - TW'(1);
            en_ready <= 1'b1;
          end
        end
        S_WR: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            en_shadow <= en_latched;
            en_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_RD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            if (rd_delta == 8'd0) begin
              en_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              trace    <= avm_readdata;
              idx      <= (rd_delta > 8'd7) ? 3'd6 : (rd_delta[2:0] - 3'd1);
              last_seq <= rd_seq;
              if (rd_delta > 8'd7)
                lost_count <= lost_next;
              state <= S_PUSH;
            end
          end
        end
        S_PUSH: begin
          if (idx == 3'd0) begin
            en_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: mem holds {seq, data}; a push while full only lands if a pop frees the slot.
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign smp_valid = (count != '0);
  assign pop       = smp_valid && smp_ready;
  assign push_ok   = push_valid && (!fifo_full || pop);
  assign smp_data  = smp_valid ? mem[rd_ptr][7:0]  : 8'd0;
  assign smp_seq   = smp_valid ? mem[rd_ptr][15:8] : 8'd0;

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= {push_seq, push_data};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_valid && fifo_full && !pop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dbg_trace_avalon_poller.sv
// Scoreboard bench: an agent model serves the trace word, a reference model derives
// expected samples from seq arithmetic, and a monitor checks each popped FIFO entry.
module tb_dbg_trace_avalon_poller;

  localparam int P = 8;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [63:0] avm_readdata = '0;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        en_valid = 1'b0;
  logic [4:0]  en_data = '0;
  logic        en_ready;
  logic [4:0]  en_shadow;
  logic        smp_valid;
  logic [7:0]  smp_data;
  logic [7:0]  smp_seq;
  logic        smp_ready = 1'b0;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic [15:0] lost_count;

  dbg_trace_avalon_poller #(.POLL_INTERVAL(P), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .en_valid(en_valid), .en_data(en_data), .en_ready(en_ready), .en_shadow(en_shadow),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_seq(smp_seq), .smp_ready(smp_ready),
    .overflow(overflow), .overflow_clr(overflow_clr), .lost_count(lost_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Agent: sample history indexed by seq, newest seq in agent_s.
  logic [7:0] hist [256];
  logic [7:0] agent_s = 8'd0;
  int         poll_cnt = 0;
  int         rd_stall = 0;
  int         wr_stall = 0;

  // Reference model state.
  typedef struct { logic [7:0] d; logic [7:0] s; } ent_t;
  ent_t       sb [$];
  logic [4:0] exp_wr [$];
  logic [7:0] m_last = 8'd0;
  int         m_lost = 0;
  bit         stalled = 1'b0;
  bit         exp_ovf = 1'b0;
  logic [4:0] exp_shadow = '0;
  int         pop_cnt = 0;
  logic [7:0] last_pop_seq = '0;

  task automatic add_sample(input logic [7:0] v);
    agent_s = agent_s + 8'd1;
    hist[agent_s] = v;
  endtask

  function automatic logic [63:0] compose();
    logic [63:0] w;
    logic [7:0]  s;
    w = '0;
    w[63:56] = agent_s;
    for (int k = 0; k < 7; k++) begin
      s = agent_s - 8'(k);
      w[8*k +: 8] = hist[s];
    end
    return w;
  endfunction

  task automatic model_read();
    logic [7:0] diff;
    int d, n;
    ent_t e;
    diff = agent_s - m_last;
    d = int'(diff);
    if (d > 0) begin
      n = (d > 7) ? 7 : d;
      if (d > 7) m_lost = (m_lost + d - 7 > 65535) ? 65535 : m_lost + d - 7;
      for (int k = n - 1; k >= 0; k--) begin
        e.s = agent_s - 8'(k);
        e.d = hist[e.s];
        if (stalled && sb.size() >= D) exp_ovf = 1'b1;
        else sb.push_back(e);
      end
      m_last = agent_s;
    end
  endtask

  bit          in_req = 1'b0;
  int          stall_left, req_cycles, req_stall;
  logic        req_wr, req_addr;
  logic [63:0] req_wd;
  logic [4:0]  wv;

  always @(negedge clock) begin
    if (!reset) begin
      in_req = 1'b0;
      avm_waitrequest = 1'b0;
    end else if (avm_read || avm_write) begin
      check("rd_wr_exclusive", {63'b0, avm_read & avm_write}, 64'd0);
      if (!in_req) begin
        in_req = 1'b1;
        req_wr = avm_write;
        req_addr = avm_address;
        req_wd = avm_writedata;
        req_stall = avm_write ? wr_stall : rd_stall;
        stall_left = req_stall;
        req_cycles = 0;
      end else begin
        check("req_stable_kind", {62'b0, avm_write, avm_address}, {62'b0, req_wr, req_addr});
        if (req_wr) check("req_stable_wdata", avm_writedata, req_wd);
      end
      req_cycles++;
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_req = 1'b0;
        if (req_wr) begin
          check("wr_addr", {63'b0, avm_address}, 64'd1);
          check("wr_hold_cycles", 64'(req_cycles), 64'(req_stall + 1));
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got write %0h expected none", avm_writedata);
          end else begin
            wv = exp_wr.pop_front();
            check("wr_data", avm_writedata, {59'b0, wv});
            exp_shadow = wv;
          end
        end else begin
          check("rd_addr", {63'b0, avm_address}, 64'd0);
          avm_readdata = compose();
          model_read();
          poll_cnt++;
        end
      end
    end else begin
      in_req = 1'b0;
      avm_waitrequest = 1'b0;
    end
  end

  ent_t me;
  always @(negedge clock) begin
    if (reset && smp_valid && smp_ready) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL smp_unexpected: got (%0h,%0h) expected none", smp_data, smp_seq);
      end else begin
        me = sb.pop_front();
        check("smp_data", {56'b0, smp_data}, {56'b0, me.d});
        check("smp_seq", {56'b0, smp_seq}, {56'b0, me.s});
      end
      pop_cnt++;
      last_pop_seq = smp_seq;
    end
  end

  task automatic wait_poll(input int extra);
    int start, i;
    start = poll_cnt;
    for (i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      if (poll_cnt != start) break;
    end
    if (i >= 400) begin
      errors++;
      $display("FAIL poll_timeout: got no read after %0d cycles expected one", i);
    end
    repeat (extra) @(posedge clock);
    #1;
  endtask

  task automatic measure_poll_latency(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 4 * P + 8; i++) begin
      @(posedge clock); #1;
      cnt++;
      if (avm_read) break;
    end
    check(name, 64'(cnt), 64'(P));
  endtask

  task automatic en_send(input logic [4:0] v);
    bit ok;
    ok = 1'b0;
    en_data = v;
    en_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (en_ready) begin
        @(posedge clock); #1;
        ok = 1'b1;
        break;
      end
    end
    en_valid = 1'b0;
    if (ok) exp_wr.push_back(v);
    else begin
      errors++;
      $display("FAIL en_handshake: got no en_ready expected acceptance");
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rw"}, {61'b0, avm_read, avm_write, avm_address}, 64'd0);
    check({name, "_wdata"}, avm_writedata, 64'd0);
    check({name, "_en"}, {58'b0, en_ready, en_shadow}, 64'd0);
    check({name, "_smp"}, {47'b0, smp_valid, smp_data, smp_seq}, 64'd0);
    check({name, "_ovf_lost"}, {47'b0, overflow, lost_count}, 64'd0);
  endtask

  int p0, bound;

  initial begin
    for (int i = 0; i < 256; i++) hist[i] = 8'd0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    smp_ready = 1'b1;
    measure_poll_latency("first_poll_latency");
    wait_poll(4);

    // Three fresh samples.
    add_sample(8'hA1); add_sample(8'hB2); add_sample(8'hC3);
    p0 = pop_cnt;
    wait_poll(12);
    check("case1_pops", 64'(pop_cnt - p0), 64'd3);
    check("case1_last_seq", {56'b0, last_pop_seq}, 64'd3);
    check("case1_lost", {48'b0, lost_count}, 64'd0);

    // 3 -> 13: window of 7, three lost.
    for (int i = 0; i < 10; i++) add_sample(8'($urandom));
    p0 = pop_cnt;
    wait_poll(12);
    check("case2_pops", 64'(pop_cnt - p0), 64'd7);
    check("case2_lost", {48'b0, lost_count}, 64'd3);

    // 13 -> 250 then wrap to 4.
    for (int i = 0; i < 237; i++) add_sample(8'($urandom));
    wait_poll(12);
    check("to250_lost", {48'b0, lost_count}, 64'd233);
    for (int i = 0; i < 10; i++) add_sample(8'($urandom));
    p0 = pop_cnt;
    wait_poll(12);
    check("wrap_pops", 64'(pop_cnt - p0), 64'd7);
    check("wrap_last_seq", {56'b0, last_pop_seq}, 64'd4);
    check("wrap_lost", {48'b0, lost_count}, 64'd236);

    // Enable write held off by four stall cycles.
    wr_stall = 4;
    en_send(5'h15);
    for (bound = 0; bound < 100 && exp_wr.size() != 0; bound++) begin
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    check("en_shadow_15", {59'b0, en_shadow}, 64'h15);
    wr_stall = 0;

    // Stalled consumer: 6 new samples into a 4-deep FIFO.
    wait_poll(12);
    check("pre_ovf_empty", {63'b0, smp_valid}, 64'd0);
    smp_ready = 1'b0;
    stalled = 1'b1;
    for (int i = 0; i < 6; i++) add_sample(8'($urandom));
    wait_poll(12);
    check("ovf_set", {63'b0, overflow}, 64'd1);
    check("ovf_model", {63'b0, overflow}, {63'b0, exp_ovf});
    check("ovf_valid", {63'b0, smp_valid}, 64'd1);
    overflow_clr = 1'b1;
    @(posedge clock); #1;
    overflow_clr = 1'b0;
    check("ovf_cleared", {63'b0, overflow}, 64'd0);
    p0 = pop_cnt;
    smp_ready = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("ovf_kept", 64'(pop_cnt - p0), 64'd4);
    check("ovf_drained", {63'b0, smp_valid}, 64'd0);
    stalled = 1'b0;
    exp_ovf = 1'b0;

    // Randomized polls, stalls and enable updates.
    for (int it = 0; it < 40; it++) begin
      rd_stall = $urandom_range(0, 3);
      wr_stall = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) en_send(5'($urandom));
      for (int k = $urandom_range(0, 12); k > 0; k--) add_sample(8'($urandom));
      wait_poll(12);
      check("rand_lost", {48'b0, lost_count}, 64'(m_lost));
      check("rand_shadow", {59'b0, en_shadow}, {59'b0, exp_shadow});
    end

    // Reset during a stalled read.
    wait_poll(12);
    rd_stall = 10;
    for (bound = 0; bound < 100 && !avm_read; bound++) @(negedge clock);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    exp_wr.delete();
    m_last = 8'd0;
    m_lost = 0;
    exp_shadow = '0;
    rd_stall = 0;
    wr_stall = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    measure_poll_latency("post_reset_poll_latency");
    wait_poll(12);
    check("post_reset_lost", {48'b0, lost_count}, 64'(m_lost));
    wait_poll(12);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_valid", {63'b0, smp_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
